// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-source result FIFOs drained one entry per
// cycle onto a registered broadcast bus, round-robin between non-empty sources.
module cdb_arbiter #(
    parameter int QDEPTH = 2,
    parameter int TAGW   = 5,
    parameter int DATAW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             alu_en_i,
    input  logic [TAGW-1:0]  alu_tag_i,
    input  logic [DATAW-1:0] alu_data_i,
    input  logic             lsb_en_i,
    input  logic [TAGW-1:0]  lsb_tag_i,
    input  logic [DATAW-1:0] lsb_data_i,
    input  logic             br_en_i,
    input  logic [TAGW-1:0]  br_tag_i,
    input  logic [DATAW-1:0] br_data_i,
    output logic             alu_full_o,
    output logic             lsb_full_o,
    output logic             br_full_o,
    output logic             cdb_en_o,
    output logic [TAGW-1:0]  cdb_tag_o,
    output logic [DATAW-1:0] cdb_data_o,
    output logic [1:0]       cdb_src_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic             en_w   [3];
    logic [TAGW-1:0]  tag_w  [3];
    logic [DATAW-1:0] data_w [3];

    logic [TAGW-1:0]  tag_mem_q  [3][QDEPTH];
    logic [DATAW-1:0] data_mem_q [3][QDEPTH];
    logic [PW-1:0]    rptr_q [3];
    logic [PW-1:0]    wptr_q [3];
    logic [CW-1:0]    cnt_q  [3];
    logic [1:0]       last_q;

    logic [2:0]       elig, full, push, pop;
    logic             found;
    logic [1:0]       win, idx;
    logic [TAGW-1:0]  head_tag;
    logic [DATAW-1:0] head_data;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign en_w[0] = alu_en_i;  assign tag_w[0] = alu_tag_i;  assign data_w[0] = alu_data_i;
    assign en_w[1] = lsb_en_i;  assign tag_w[1] = lsb_tag_i;  assign data_w[1] = lsb_data_i;
    assign en_w[2] = br_en_i;   assign tag_w[2] = br_tag_i;   assign data_w[2] = br_data_i;

    assign alu_full_o = full[0];
    assign lsb_full_o = full[1];
    assign br_full_o  = full[2];

    // Eligibility and fullness look only at the count at the start of the cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            elig[i] = (cnt_q[i] != '0);
            full[i] = (cnt_q[i] == FULL_CNT);
        end
    end

    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = next_idx(last_q);
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_idx(idx);
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            push[i] = rdy && !clear && en_w[i] && !full[i];
            pop[i]  = rdy && !clear && found && (win == 2'(i));
        end
    end

    always_comb begin
        head_tag  = tag_mem_q[0][rptr_q[0]];
        head_data = data_mem_q[0][rptr_q[0]];
        case (win)
            2'd1: begin
                head_tag  = tag_mem_q[1][rptr_q[1]];
                head_data = data_mem_q[1][rptr_q[1]];
            end
            2'd2: begin
                head_tag  = tag_mem_q[2][rptr_q[2]];
                head_data = data_mem_q[2][rptr_q[2]];
            end
            default: ;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i] && !rst) begin
                tag_mem_q[i][wptr_q[i]]  <= tag_w[i];
                data_mem_q[i][wptr_q[i]] <= data_w[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (rdy && clear)) begin
            for (int i = 0; i < 3; i++) begin
                rptr_q[i] <= '0;
                wptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            cdb_en_o   <= 1'b0;
            cdb_tag_o  <= '0;
            cdb_data_o <= '0;
            cdb_src_o  <= 2'd0;
            last_q     <= 2'd2;
        end else if (rdy) begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (found) begin
                cdb_en_o   <= 1'b1;
                cdb_tag_o  <= head_tag;
                cdb_data_o <= head_data;
                cdb_src_o  <= win;
                last_q     <= win;
            end else begin
                cdb_en_o   <= 1'b0;
                cdb_tag_o  <= '0;
                cdb_data_o <= '0;
                cdb_src_o  <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-source scoreboards filled as pushes are driven and
// drained as broadcasts appear, plus scenario tasks checking grant order and flags.
module tb_cdb_arbiter;
    localparam int QDEPTH = 2;
    localparam int TAGW   = 5;
    localparam int DATAW  = 32;

    logic             clk = 1'b0;
    logic             rst, rdy, clear;
    logic             alu_en_i, lsb_en_i, br_en_i;
    logic [TAGW-1:0]  alu_tag_i, lsb_tag_i, br_tag_i;
    logic [DATAW-1:0] alu_data_i, lsb_data_i, br_data_i;
    logic             alu_full_o, lsb_full_o, br_full_o;
    logic             cdb_en_o;
    logic [TAGW-1:0]  cdb_tag_o;
    logic [DATAW-1:0] cdb_data_o;
    logic [1:0]       cdb_src_o;

    always #5 clk = ~clk;

    cdb_arbiter #(.QDEPTH(QDEPTH), .TAGW(TAGW), .DATAW(DATAW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alu_en_i(alu_en_i), .alu_tag_i(alu_tag_i), .alu_data_i(alu_data_i),
        .lsb_en_i(lsb_en_i), .lsb_tag_i(lsb_tag_i), .lsb_data_i(lsb_data_i),
        .br_en_i(br_en_i), .br_tag_i(br_tag_i), .br_data_i(br_data_i),
        .alu_full_o(alu_full_o), .lsb_full_o(lsb_full_o), .br_full_o(br_full_o),
        .cdb_en_o(cdb_en_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
        .cdb_src_o(cdb_src_o)
    );

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
    } ent_t;

    ent_t sb0[$], sb1[$], sb2[$];
    int   checks = 0;
    int   errors = 0;
    bit   bcast_e = 1'b0;
    ent_t mon_got, mon_exp;
    bit   mon_have;

    // A broadcast is new only if the edge that produced it was enabled.
    always @(posedge clk) begin
        bcast_e = rdy && !rst;
        if (rst || (rdy && clear)) begin
            sb0.delete();
            sb1.delete();
            sb2.delete();
        end
    end

    always @(negedge clk) begin
        if (bcast_e && cdb_en_o === 1'b1) begin
            mon_got  = {cdb_tag_o, cdb_data_o};
            mon_have = 1'b0;
            mon_exp  = '0;
            case (cdb_src_o)
                2'd0: if (sb0.size() > 0) begin mon_exp = sb0.pop_front(); mon_have = 1'b1; end
                2'd1: if (sb1.size() > 0) begin mon_exp = sb1.pop_front(); mon_have = 1'b1; end
                2'd2: if (sb2.size() > 0) begin mon_exp = sb2.pop_front(); mon_have = 1'b1; end
                default: ;
            endcase
            checks++;
            if (!mon_have) begin
                errors++;
                $display("FAIL sb_unexpected src=%0d tag=%0d data=%h required=no broadcast",
                         cdb_src_o, cdb_tag_o, cdb_data_o);
            end else if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL sb_entry src=%0d got tag=%0d data=%h required tag=%0d data=%h",
                         cdb_src_o, mon_got.tag, mon_got.data, mon_exp.tag, mon_exp.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_en_i = 1'b0;
        lsb_en_i = 1'b0;
        br_en_i  = 1'b0;
    endtask

    task automatic push(input int src, input logic [TAGW-1:0] t,
                        input logic [DATAW-1:0] d, input bit acc);
        case (src)
            0: begin alu_en_i = 1'b1; alu_tag_i = t; alu_data_i = d; if (acc) sb0.push_back({t, d}); end
            1: begin lsb_en_i = 1'b1; lsb_tag_i = t; lsb_data_i = d; if (acc) sb1.push_back({t, d}); end
            default: begin br_en_i = 1'b1; br_tag_i = t; br_data_i = d; if (acc) sb2.push_back({t, d}); end
        endcase
    endtask

    task automatic apply_reset;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b0; clear = 1'b1;
        idle();
        alu_en_i = 1'b1; alu_tag_i = 5'd9; alu_data_i = 32'hFFFF_0000;
        tick();
        tick();
        checks++;
        if ({cdb_en_o, cdb_src_o} !== 3'b000) begin
            errors++; $display("FAIL reset_en_src got=%b required=000", {cdb_en_o, cdb_src_o});
        end
        checks++;
        if ({cdb_tag_o, cdb_data_o} !== '0) begin
            errors++; $display("FAIL reset_fields got tag=%0d data=%h required=0", cdb_tag_o, cdb_data_o);
        end
        checks++;
        if ({alu_full_o, lsb_full_o, br_full_o} !== 3'b000) begin
            errors++; $display("FAIL reset_full got=%b required=000", {alu_full_o, lsb_full_o, br_full_o});
        end
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_latency;
        apply_reset();
        push(0, 5'd3, 32'h11, 1'b1);
        tick();
        idle();
        checks++;
        if (cdb_en_o !== 1'b0) begin
            errors++; $display("FAIL lat_no_bypass got en=%b required=0", cdb_en_o);
        end
        tick();
        checks++;
        if ({cdb_en_o, cdb_src_o, cdb_tag_o, cdb_data_o} !== {1'b1, 2'd0, 5'd3, 32'h11}) begin
            errors++; $display("FAIL lat_bcast got en=%b src=%0d tag=%0d data=%h required en=1 src=0 tag=3 data=11",
                               cdb_en_o, cdb_src_o, cdb_tag_o, cdb_data_o);
        end
        tick();
        checks++;
        if (cdb_en_o !== 1'b0) begin
            errors++; $display("FAIL lat_single got en=%b required=0", cdb_en_o);
        end
    endtask

    task automatic test_three;
        logic [2:0] exp_s [4];
        exp_s = '{3'b100, 3'b101, 3'b110, 3'b000};
        apply_reset();
        push(0, 5'd1, 32'hA, 1'b1);
        push(1, 5'd2, 32'hB, 1'b1);
        push(2, 5'd3, 32'hC, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== exp_s[i]) begin
                errors++; $display("FAIL three_order[%0d] got=%b required=%b", i, {cdb_en_o, cdb_src_o}, exp_s[i]);
            end
        end
    endtask

    task automatic test_full;
        logic [2:0] exp_s [3];
        exp_s = '{3'b110, 3'b101, 3'b000};
        apply_reset();
        push(1, 5'd4, 32'h44, 1'b1);
        push(0, 5'd10, 32'hA0, 1'b1);
        push(2, 5'd20, 32'hB0, 1'b1);
        tick();
        idle();
        checks++;
        if (lsb_full_o !== 1'b0) begin
            errors++; $display("FAIL full_one got=%b required=0", lsb_full_o);
        end
        push(1, 5'd5, 32'h55, 1'b1);
        tick();
        idle();
        checks++;
        if ({lsb_full_o, cdb_en_o, cdb_src_o} !== 4'b1100) begin
            errors++; $display("FAIL full_two got full/en/src=%b required=1100", {lsb_full_o, cdb_en_o, cdb_src_o});
        end
        push(1, 5'd6, 32'h66, 1'b0);
        tick();
        idle();
        checks++;
        if ({lsb_full_o, cdb_en_o, cdb_src_o} !== 4'b0101) begin
            errors++; $display("FAIL full_drop got full/en/src=%b required=0101", {lsb_full_o, cdb_en_o, cdb_src_o});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== exp_s[i]) begin
                errors++; $display("FAIL full_order[%0d] got=%b required=%b", i, {cdb_en_o, cdb_src_o}, exp_s[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        int src;
        logic [2:0] exp_s [3];
        exp_s = '{3'b100, 3'b110, 3'b000};
        apply_reset();
        push(0, 5'd0, $urandom, 1'b1);
        push(2, 5'd16, $urandom, 1'b1);
        tick();
        idle();
        for (int k = 1; k <= 8; k++) begin
            src = (k % 2 == 1) ? 0 : 2;
            push(src, (src == 0) ? 5'(k) : 5'(16 + k), $urandom, 1'b1);
            tick();
            idle();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== {1'b1, 2'(src)}) begin
                errors++; $display("FAIL rr_grant[%0d] got=%b required=%b", k, {cdb_en_o, cdb_src_o}, {1'b1, 2'(src)});
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== exp_s[i]) begin
                errors++; $display("FAIL rr_drain[%0d] got=%b required=%b", i, {cdb_en_o, cdb_src_o}, exp_s[i]);
            end
        end
    endtask

    task automatic test_freeze;
        logic [2:0] exp_s [3];
        exp_s = '{3'b101, 3'b110, 3'b000};
        apply_reset();
        push(0, 5'd21, 32'h2121, 1'b1);
        push(1, 5'd22, 32'h2222, 1'b1);
        push(2, 5'd23, 32'h2323, 1'b1);
        tick();
        idle();
        tick();
        rdy = 1'b0;
        push(2, 5'd30, 32'h3030, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o, cdb_tag_o, alu_full_o, lsb_full_o, br_full_o} !== {1'b1, 2'd0, 5'd21, 3'b000}) begin
                errors++; $display("FAIL freeze_hold[%0d] got en=%b src=%0d tag=%0d full=%b required en=1 src=0 tag=21 full=000",
                                   i, cdb_en_o, cdb_src_o, cdb_tag_o, {alu_full_o, lsb_full_o, br_full_o});
            end
        end
        idle();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== exp_s[i]) begin
                errors++; $display("FAIL freeze_resume[%0d] got=%b required=%b", i, {cdb_en_o, cdb_src_o}, exp_s[i]);
            end
        end
    endtask

    task automatic test_clear;
        logic [2:0] exp_s [3];
        exp_s = '{3'b100, 3'b101, 3'b000};
        apply_reset();
        push(0, 5'd1, 32'h1, 1'b1); push(1, 5'd2, 32'h2, 1'b1); push(2, 5'd3, 32'h3, 1'b1);
        tick();
        idle();
        push(0, 5'd4, 32'h4, 1'b1); push(1, 5'd5, 32'h5, 1'b1); push(2, 5'd6, 32'h6, 1'b1);
        tick();
        idle();
        push(0, 5'd7, 32'h7, 1'b1);
        tick();
        idle();
        checks++;
        if ({alu_full_o, lsb_full_o, br_full_o, cdb_en_o, cdb_src_o} !== 6'b101101) begin
            errors++; $display("FAIL clear_pre got full/en/src=%b required=101101",
                               {alu_full_o, lsb_full_o, br_full_o, cdb_en_o, cdb_src_o});
        end
        clear = 1'b1;
        push(0, 5'd9, 32'h9, 1'b0);
        tick();
        clear = 1'b0;
        idle();
        checks++;
        if ({cdb_en_o, cdb_src_o, cdb_tag_o, cdb_data_o, alu_full_o, lsb_full_o, br_full_o} !== '0) begin
            errors++; $display("FAIL clear_post got en=%b tag=%0d data=%h full=%b required all 0",
                               cdb_en_o, cdb_tag_o, cdb_data_o, {alu_full_o, lsb_full_o, br_full_o});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cdb_en_o !== 1'b0) begin
                errors++; $display("FAIL clear_quiet[%0d] got en=%b required=0", i, cdb_en_o);
            end
        end
        push(0, 5'd11, 32'hB11, 1'b1);
        push(1, 5'd12, 32'hB12, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cdb_en_o, cdb_src_o} !== exp_s[i]) begin
                errors++; $display("FAIL clear_after[%0d] got=%b required=%b", i, {cdb_en_o, cdb_src_o}, exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        push(0, 5'd13, 32'hD13, 1'b1);
        push(1, 5'd14, 32'hD14, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if ({cdb_en_o, cdb_src_o} !== 3'b100) begin
            errors++; $display("FAIL rstmid_pre got=%b required=100", {cdb_en_o, cdb_src_o});
        end
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        checks++;
        if ({cdb_en_o, cdb_src_o, cdb_tag_o, cdb_data_o} !== '0) begin
            errors++; $display("FAIL rstmid_out got en=%b src=%0d tag=%0d data=%h required all 0",
                               cdb_en_o, cdb_src_o, cdb_tag_o, cdb_data_o);
        end
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cdb_en_o !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet[%0d] got en=%b required=0", i, cdb_en_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_tag_i = '0; lsb_tag_i = '0; br_tag_i = '0;
        alu_data_i = '0; lsb_data_i = '0; br_data_i = '0;
        test_reset();
        test_latency();
        test_three();
        test_full();
        test_round_robin();
        test_freeze();
        test_clear();
        test_reset_mid();
        tick();
        checks++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d entries never broadcast required=0",
                               sb0.size() + sb1.size() + sb2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
